// File: rtl/data_mem_port_pkg.sv
// data_mem_port_pkg: shared memory-defines (load/store encodings, data-memory FSM states)
package data_mem_port_pkg;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LH   = 3'd2,
        LD_LW   = 3'd3,
        LD_LBU  = 3'd4,
        LD_LHU  = 3'd5
    } load_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SB   = 2'd1,
        ST_SH   = 2'd2,
        ST_SW   = 2'd3
    } store_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: picks the addressed byte/halfword of a memory word and sign- or zero-extends it
module dmem_load_align
    import data_mem_port_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [2:0]  load_sel,
    input  logic [1:0]  offset,
    output logic [31:0] load_data
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = mem_word[8*offset +: 8];
    assign h = offset[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        load_data = load_sel == LD_LB  ? {{24{b[7]}}, b} :
                    load_sel == LD_LBU ? {24'b0, b} :
                    load_sel == LD_LH  ? {{16{h[15]}}, h} :
                    load_sel == LD_LHU ? {16'b0, h} : mem_word;
    end

endmodule

// File: rtl/data_mem_port.sv
// data_mem_port: multi-cycle data memory with byte/half/word loads and stores.
// Define DMEM_MISALIGN_TRAP_EN to flag and suppress misaligned accesses instead of truncating them.
module data_mem_port
    import data_mem_port_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [2:0]  LOADSIGNAL,
    input  logic [1:0]  STORESIGNAL,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT,
    output logic        MISALIGN
);

    localparam int AW = $clog2(MEM_WORDS);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [2:0]      ls_q, ls_d;
    logic [1:0]      ss_q, ss_d;
    logic            store_q, store_d;
    logic            mis_q, mis_d;
    logic [31:0]     mem_q [MEM_WORDS];
    logic [31:0]     mem_word, aligned, lanes;
    logic [3:0]      be;
    logic            req, commit, misaligned, unused_addr;

    assign unused_addr = ^ADDRESS[31:AW+2];
    assign req         = READ | WRITE;
    assign commit      = state_q == S_ACCESS && cnt_q == 4'd0;
    assign mem_word    = mem_q[addr_q[AW+1:2]];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = store_q
        ? ((ss_q == ST_SH && addr_q[0]) || (ss_q == ST_SW && addr_q[1:0] != 2'b00))
        : (((ls_q == LD_LH || ls_q == LD_LHU) && addr_q[0]) || (ls_q == LD_LW && addr_q[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Low address bits beyond natural alignment are simply not looked at by the lane logic
    assign be    = ss_q == ST_SB ? 4'b0001 << addr_q[1:0] :
                   ss_q == ST_SH ? (addr_q[1] ? 4'b1100 : 4'b0011) :
                   ss_q == ST_SW ? 4'b1111 : 4'b0000;
    assign lanes = ss_q == ST_SB ? {4{wdata_q[7:0]}} :
                   ss_q == ST_SH ? {2{wdata_q[15:0]}} : wdata_q;

    dmem_load_align u_align (
        .mem_word (mem_word),
        .load_sel (ls_q),
        .offset   (addr_q[1:0]),
        .load_data(aligned)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ls_d    = ls_q;
        ss_d    = ss_q;
        store_d = store_q;
        mis_d   = 1'b0;
        case (state_q)
            S_IDLE: if (req) begin
                state_d = S_ACCESS;
                cnt_d   = 4'(LATENCY - 1);
                addr_d  = ADDRESS[AW+1:0];
                wdata_d = WRITEDATA;
                ls_d    = LOADSIGNAL;
                ss_d    = STORESIGNAL;
                store_d = WRITE;
            end
            S_ACCESS: if (cnt_q == 4'd0) begin
                state_d = S_DONE;
                mis_d   = misaligned;
                rdata_d = (!store_q && !misaligned) ? aligned : rdata_q;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ls_q    <= 3'd0;
            ss_q    <= 2'd0;
            store_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ls_q    <= ls_d;
            ss_q    <= ss_d;
            store_q <= store_d;
            mis_q   <= mis_d;
        end
    end

    // The array has no reset; a reset at the commit edge drops the store
    always_ff @(posedge CLK) begin
        if (RESET && commit && store_q && !misaligned)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_q[addr_q[AW+1:2]][8*i +: 8] <= lanes[8*i +: 8];
    end

    assign READDATA = rdata_q;
    assign MISALIGN = mis_q;
    assign BUSYWAIT = (state_q == S_IDLE && req) || state_q == S_ACCESS;

endmodule
